// File: rtl/video_frame_pkg.sv
// Shared types and helpers for video_frame_gen.
//   state_t    : frame timing FSM states
//   cnt_width  : counter width able to index 0..n-1 (min 1 bit)
//   max2       : larger of two values, for sizing shared counters
package video_frame_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LEAD   = 3'd1,
        ST_ACTIVE = 3'd2,
        ST_HBLANK = 3'd3,
        ST_VBLANK = 3'd4
    } state_t;

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/video_frame_gen.sv
// video_frame_gen: free-running video frame source (vsync/href/pixel) fed by
// a valid/ready pixel stream. Timing never stalls; a missing pixel is sent as
// 0 and latched in the sticky underflow flag.
//
// Ports:
//   clk, rst            pixel clock, asynchronous active-high reset
//   enable              frames are generated while high (checked in IDLE and
//                       at the end of VBLANK)
//   tpg_mode            (only with VIDEO_FRAME_GEN_TPG_EN) test pattern select,
//                       sampled at LEAD entry
//   s_valid, s_data     upstream pixel stream
//   s_ready             combinational request: next cycle is an active pixel
//   out_frame_vsync     high over lead + all lines of a frame
//   out_frame_href      high on active pixels
//   out_img_data        pixel, 0 while href is low
//   frame_done          one-cycle pulse on the vsync falling cycle
//   underflow           sticky: an active pixel had no valid data
//
// Optional feature macro: VIDEO_FRAME_GEN_TPG_EN (test pattern generator).
module video_frame_gen
    import video_frame_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned IMG_HDISP  = 640,
    parameter int unsigned IMG_VDISP  = 480,
    parameter int unsigned H_BLANK    = 16,
    parameter int unsigned VS_LEAD    = 16,
    parameter int unsigned V_BLANK    = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
`ifdef VIDEO_FRAME_GEN_TPG_EN
    input  logic                  tpg_mode,
`endif
    input  logic                  s_valid,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  s_ready,
    output logic                  out_frame_vsync,
    output logic                  out_frame_href,
    output logic [DATA_WIDTH-1:0] out_img_data,
    output logic                  frame_done,
    output logic                  underflow
);

    localparam int unsigned HW = cnt_width(max2(max2(IMG_HDISP, H_BLANK), max2(VS_LEAD, V_BLANK)));
    localparam int unsigned VW = cnt_width(IMG_VDISP);

    localparam logic [HW-1:0] LEAD_LAST = HW'(VS_LEAD - 1);
    localparam logic [HW-1:0] ACT_LAST  = HW'(IMG_HDISP - 1);
    localparam logic [HW-1:0] HB_LAST   = HW'(H_BLANK - 1);
    localparam logic [HW-1:0] VB_LAST   = HW'(V_BLANK - 1);
    localparam logic [VW-1:0] LINE_LAST = VW'(IMG_VDISP - 1);

    state_t                  state_q, state_d;
    logic [HW-1:0]           h_cnt_q, h_cnt_d;
    logic [VW-1:0]           v_cnt_q, v_cnt_d;
    logic                    vsync_q, vsync_d;
    logic                    href_q, href_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic                    done_q, done_d;
    logic                    unf_q, unf_d;
    logic                    tpg_on;
    logic                    pix_slot;

`ifdef VIDEO_FRAME_GEN_TPG_EN
    localparam int unsigned SW = max2(HW, VW) + 1;

    logic          tpg_q, tpg_d;
    logic [SW-1:0] tpg_sum;

    assign tpg_on = tpg_q;
`else
    assign tpg_on = 1'b0;
`endif

    // Timing FSM, counters and next values of every registered output.
    always_comb begin
        state_d  = state_q;
        h_cnt_d  = h_cnt_q;
        v_cnt_d  = v_cnt_q;
        unf_d    = unf_q;
        s_ready  = 1'b0;
        data_d   = '0;
`ifdef VIDEO_FRAME_GEN_TPG_EN
        tpg_d    = tpg_q;
        tpg_sum  = '0;
`endif

        unique case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d = ST_LEAD;
                    h_cnt_d = '0;
                    v_cnt_d = '0;
                end
            end
            ST_LEAD: begin
                if (h_cnt_q == LEAD_LAST) begin
                    state_d = ST_ACTIVE;
                    h_cnt_d = '0;
                end else begin
                    h_cnt_d = h_cnt_q + HW'(1);
                end
            end
            ST_ACTIVE: begin
                if (h_cnt_q == ACT_LAST) begin
                    state_d = ST_HBLANK;
                    h_cnt_d = '0;
                end else begin
                    h_cnt_d = h_cnt_q + HW'(1);
                end
            end
            ST_HBLANK: begin
                if (h_cnt_q == HB_LAST) begin
                    h_cnt_d = '0;
                    if (v_cnt_q == LINE_LAST) begin
                        state_d = ST_VBLANK;
                        v_cnt_d = '0;
                    end else begin
                        state_d = ST_ACTIVE;
                        v_cnt_d = v_cnt_q + VW'(1);
                    end
                end else begin
                    h_cnt_d = h_cnt_q + HW'(1);
                end
            end
            ST_VBLANK: begin
                if (h_cnt_q == VB_LAST) begin
                    state_d = enable ? ST_LEAD : ST_IDLE;
                    h_cnt_d = '0;
                end else begin
                    h_cnt_d = h_cnt_q + HW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                h_cnt_d = '0;
                v_cnt_d = '0;
            end
        endcase

        // Outputs are registered from the next state, so they describe the
        // cycle that state_d is about to become.
        pix_slot = (state_d == ST_ACTIVE);
        vsync_d  = (state_d == ST_LEAD) || (state_d == ST_ACTIVE) || (state_d == ST_HBLANK);
        href_d   = pix_slot;
        done_d   = (state_q == ST_HBLANK) && (state_d == ST_VBLANK);

`ifdef VIDEO_FRAME_GEN_TPG_EN
        if ((state_d == ST_LEAD) && (state_q != ST_LEAD)) begin
            tpg_d = tpg_mode;
        end
        tpg_sum = SW'(h_cnt_d) + SW'(v_cnt_d);
`endif

        s_ready = pix_slot && !tpg_on;

        if (pix_slot) begin
`ifdef VIDEO_FRAME_GEN_TPG_EN
            if (tpg_on) begin
                data_d = DATA_WIDTH'(tpg_sum);
            end else if (s_valid) begin
                data_d = s_data;
            end
`else
            if (s_valid) begin
                data_d = s_data;
            end
`endif
        end

        // A fresh start from IDLE forgets earlier underflows.
        if ((state_q == ST_IDLE) && (state_d == ST_LEAD)) begin
            unf_d = 1'b0;
        end
        if (s_ready && !s_valid) begin
            unf_d = 1'b1;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            h_cnt_q <= '0;
            v_cnt_q <= '0;
            vsync_q <= 1'b0;
            href_q  <= 1'b0;
            data_q  <= '0;
            done_q  <= 1'b0;
            unf_q   <= 1'b0;
`ifdef VIDEO_FRAME_GEN_TPG_EN
            tpg_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
            vsync_q <= vsync_d;
            href_q  <= href_d;
            data_q  <= data_d;
            done_q  <= done_d;
            unf_q   <= unf_d;
`ifdef VIDEO_FRAME_GEN_TPG_EN
            tpg_q   <= tpg_d;
`endif
        end
    end

    assign out_frame_vsync = vsync_q;
    assign out_frame_href  = href_q;
    assign out_img_data    = data_q;
    assign frame_done      = done_q;
    assign underflow       = unf_q;

endmodule

// File: tb/tb_video_frame_gen.sv
// Directed bench for video_frame_gen with a small frame:
// HDISP=4, VDISP=3, H_BLANK=2, VS_LEAD=3, V_BLANK=5 -> 21 vsync cycles,
// 26-cycle frame period, 12 active pixels per frame.
module tb_video_frame_gen;

    localparam int unsigned DW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable;
    logic          s_valid;
    logic [DW-1:0] s_data;
    logic          s_ready;
    logic          out_frame_vsync;
    logic          out_frame_href;
    logic [DW-1:0] out_img_data;
    logic          frame_done;
    logic          underflow;
`ifdef VIDEO_FRAME_GEN_TPG_EN
    logic          tpg_mode;
`endif

    int checks   = 0;
    int failures = 0;

    // Per-window observations.
    int          rel;
    int          vs_cnt;
    int          rdy_cnt;
    int          first_vs;
    int          run;
    int          drop_rel;
    int          en_off_rel;
    logic        prev_vs;
    int          fd_q[$];
    logic [DW-1:0] hq[$];

    int exp2[12] = '{24, 25, 26, 27, 28, 29, 0, 30, 31, 32, 33, 34};
    int exp5[12] = '{0, 1, 2, 3, 1, 2, 3, 4, 2, 3, 4, 5};

    video_frame_gen #(
        .DATA_WIDTH (DW),
        .IMG_HDISP  (4),
        .IMG_VDISP  (3),
        .H_BLANK    (2),
        .VS_LEAD    (3),
        .V_BLANK    (5)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .enable          (enable),
`ifdef VIDEO_FRAME_GEN_TPG_EN
        .tpg_mode        (tpg_mode),
`endif
        .s_valid         (s_valid),
        .s_data          (s_data),
        .s_ready         (s_ready),
        .out_frame_vsync (out_frame_vsync),
        .out_frame_href  (out_frame_href),
        .out_img_data    (out_img_data),
        .frame_done      (frame_done),
        .underflow       (underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clear();
        rel        = 0;
        vs_cnt     = 0;
        rdy_cnt    = 0;
        first_vs   = -1;
        run        = 0;
        prev_vs    = 1'b0;
        drop_rel   = -1;
        en_off_rel = -1;
        fd_q.delete();
        hq.delete();
    endtask

    // Sample n cycles (at posedge+1), then drive the next cycle's inputs.
    task automatic mon(input int n);
        logic xfer;
        for (int i = 0; i < n; i++) begin
            if (out_frame_vsync) begin
                vs_cnt++;
                if (first_vs < 0) first_vs = rel;
            end
            if (out_frame_href) begin
                hq.push_back(out_img_data);
                run++;
            end else begin
                check("blank_data", 32'(out_img_data), 32'd0);
                if (run != 0) begin
                    check("burst_len", 32'(run), 32'd4);
                    run = 0;
                end
            end
            if (frame_done) begin
                fd_q.push_back(rel);
                check("fd_on_vs_fall", {30'd0, prev_vs, out_frame_vsync}, 32'd2);
            end
            prev_vs = out_frame_vsync;
            if (drop_rel >= 0) s_valid = (rel != drop_rel);
            if (rel == en_off_rel) enable = 1'b0;
            if (s_ready) rdy_cnt++;
            xfer = s_ready && s_valid;
            @(posedge clk);
            #1;
            if (xfer) s_data = s_data + 8'd1;
            rel++;
        end
    endtask

    initial begin
        rst     = 1'b1;
        enable  = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
`ifdef VIDEO_FRAME_GEN_TPG_EN
        tpg_mode = 1'b0;
`endif
        clear();

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check("rst_vsync", 32'(out_frame_vsync), 32'd0);
        check("rst_href", 32'(out_frame_href), 32'd0);
        check("rst_data", 32'(out_img_data), 32'd0);
        check("rst_done", 32'(frame_done), 32'd0);
        check("rst_underflow", 32'(underflow), 32'd0);
        check("rst_ready", 32'(s_ready), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Two back-to-back frames with continuous valid data.
        enable  = 1'b1;
        s_valid = 1'b1;
        clear();
        mon(53);
        check("t1_first_vs", 32'(first_vs), 32'd1);
        check("t1_vs_cycles", 32'(vs_cnt), 32'd42);
        check("t1_href_cycles", 32'(hq.size()), 32'd24);
        check("t1_fd_count", 32'(fd_q.size()), 32'd2);
        check("t1_fd0_cycle", 32'(fd_q[0]), 32'd22);
        check("t1_fd1_cycle", 32'(fd_q[1]), 32'd48);
        for (int k = 0; k < 24; k++) check("t1_pixel", 32'(hq[k]), 32'(k));
        check("t1_underflow", 32'(underflow), 32'd0);

        // Missing pixel at line 1 pixel 2.
        clear();
        drop_rel = 10;
        mon(10);
        check("t2_unf_before", 32'(underflow), 32'd0);
        mon(1);
        check("t2_unf_set", 32'(underflow), 32'd1);
        mon(15);
        check("t2_vs_cycles", 32'(vs_cnt), 32'd21);
        check("t2_href_cycles", 32'(hq.size()), 32'd12);
        check("t2_fd_cycle", 32'(fd_q[0]), 32'd21);
        for (int k = 0; k < 12; k++) check("t2_pixel", 32'(hq[k]), 32'(exp2[k]));
        check("t2_unf_sticky", 32'(underflow), 32'd1);

        // Enable dropped during line 0: frame completes, then IDLE.
        clear();
        check("t3_unf_across_frames", 32'(underflow), 32'd1);
        en_off_rel = 4;
        mon(32);
        check("t3_vs_cycles", 32'(vs_cnt), 32'd21);
        check("t3_href_cycles", 32'(hq.size()), 32'd12);
        check("t3_first_pix", 32'(hq[0]), 32'd35);
        check("t3_last_pix", 32'(hq[11]), 32'd46);
        check("t3_fd_count", 32'(fd_q.size()), 32'd1);
        check("t3_fd_cycle", 32'(fd_q[0]), 32'd21);
        check("t3_ready_count", 32'(rdy_cnt), 32'd12);
        check("t3_idle_ready", 32'(s_ready), 32'd0);
        check("t3_idle_vsync", 32'(out_frame_vsync), 32'd0);
        check("t3_idle_unf", 32'(underflow), 32'd1);

        // Restart from IDLE clears underflow; then reset during ACTIVE.
        enable = 1'b1;
        clear();
        mon(1);
        check("t4_vs_rise", 32'(out_frame_vsync), 32'd1);
        check("t4_unf_cleared", 32'(underflow), 32'd0);
        mon(4);
        check("t4_in_active", 32'(out_frame_href), 32'd1);
        #1;
        rst = 1'b1;
        #1;
        check("t4_rst_vsync", 32'(out_frame_vsync), 32'd0);
        check("t4_rst_href", 32'(out_frame_href), 32'd0);
        check("t4_rst_data", 32'(out_img_data), 32'd0);
        check("t4_rst_ready", 32'(s_ready), 32'd0);
        @(posedge clk);
        #1;
        check("t4_rst_hold_vsync", 32'(out_frame_vsync), 32'd0);
        rst    = 1'b0;
        s_data = '0;
        clear();
        mon(27);
        check("t4_first_vs", 32'(first_vs), 32'd1);
        check("t4_vs_cycles", 32'(vs_cnt), 32'd21);
        check("t4_href_cycles", 32'(hq.size()), 32'd12);
        check("t4_fd_cycle", 32'(fd_q[0]), 32'd22);
        for (int k = 0; k < 12; k++) check("t4_pixel", 32'(hq[k]), 32'(k));

`ifdef VIDEO_FRAME_GEN_TPG_EN
        // Test pattern: takes effect from the next LEAD entry.
        tpg_mode = 1'b1;
        mon(26);
        s_valid = 1'b0;
        clear();
        mon(26);
        check("t5_ready_count", 32'(rdy_cnt), 32'd0);
        check("t5_vs_cycles", 32'(vs_cnt), 32'd21);
        check("t5_href_cycles", 32'(hq.size()), 32'd12);
        for (int k = 0; k < 12; k++) check("t5_pixel", 32'(hq[k]), 32'(exp5[k]));
        check("t5_underflow", 32'(underflow), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/video_frame_gen.md
Name: video_frame_gen

Overview:
Video stream source that drives the per-frame vsync/href/pixel interface consumed by the window generators and filters in the image pipeline. It owns frame timing, with H/V counters and blanking, and never stalls. It pulls pixels from an upstream buffer over a valid/ready handshake. Typical use: a DDR read FIFO or a testbench feeding the 3x3 matrix and Sobel chain.

Parameters:
DATA_WIDTH, 8, pixel width
IMG_HDISP, 640, active pixels per line
IMG_VDISP, 480, active lines per frame
H_BLANK, 16, href-low cycles after each active line (>=1)
VS_LEAD, 16, cycles of vsync high before the first href (>=1)
V_BLANK, 32, vsync-low cycles between frames (>=1)

Ports:
clk  in  1  pixel clock
rst  in  1  asynchronous reset, active-high
enable  in  1  level; frames are generated while high
s_valid  in  1  upstream pixel valid
s_data  in  DATA_WIDTH  upstream pixel
s_ready  out  1  pixel request; a transfer occurs when s_valid&s_ready
out_frame_vsync  out  1  high for the whole frame (lead + all lines)
out_frame_href  out  1  high on active pixels
out_img_data  out  DATA_WIDTH  pixel; 0 whenever href low
frame_done  out  1  one-cycle pulse on the cycle vsync falls
underflow  out  1  sticky; set when an active pixel had no valid data

Behaviour:
- Reset (async, immediate): state IDLE, counters 0, all outputs 0 including underflow.
- States:
  - IDLE -> LEAD when enable=1.
  - LEAD: VS_LEAD cycles, vsync=1, href=0.
  - ACTIVE: IMG_HDISP cycles.
  - HBLANK: H_BLANK cycles. Goes to ACTIVE with line_cnt+1, or to VBLANK after line IMG_VDISP-1.
  - VBLANK: V_BLANK cycles, vsync=0. Then goes to LEAD if enable=1, else IDLE.
- All outputs are registered. s_ready is combinational and equals 1 exactly on cycles whose next cycle is an ACTIVE pixel. out_img_data/href therefore lag the handshake by one cycle.
- Pixel transfer at cycle t: out_img_data=s_data and href=1 at t+1.
- If s_valid=0 while s_ready=1: href still asserts at t+1 with data=0, and underflow sets. Timing never stalls.
- underflow clears only on rst, or on an IDLE->LEAD transition.
- Frame length: vsync is high for exactly VS_LEAD + IMG_VDISP*(IMG_HDISP+H_BLANK) cycles. href is high for IMG_HDISP*IMG_VDISP cycles per frame.
- frame_done pulses in the first VBLANK output cycle, coincident with vsync 1->0.
- Enable deasserted mid-frame: the current frame completes, including VBLANK, then the block enters IDLE. Enable re-asserted during VBLANK: the next frame starts back-to-back.
- Enable asserted in IDLE: vsync rises 1 cycle later.
- Counters: h_cnt width is clog2 of max(IMG_HDISP, H_BLANK, VS_LEAD, V_BLANK); v_cnt width is clog2(IMG_VDISP). Both wrap to 0 at the terminal count, with no overflow beyond it.
- Reset asserted mid-line: outputs drop in the same cycle. After release the block restarts from IDLE and no partial frame resumes.

Optional Feature:
VIDEO_FRAME_GEN_TPG_EN.
- Defined: adds input tpg_mode (1 bit), sampled at LEAD entry and held for the frame.
  - When 1: s_ready is held 0, pixel = (h_cnt + v_cnt) truncated to DATA_WIDTH, and underflow never sets.
- Undefined: no tpg_mode port; data comes only from s_data.

Decomposition:
- Package video_frame_pkg: state enum (IDLE, LEAD, ACTIVE, HBLANK, VBLANK) and a clog2-based counter width function.
- Single module; no sub-module. The timing counters and FSM are tightly coupled.

Test Plan:
- Params HDISP=4, VDISP=3, H_BLANK=2, VS_LEAD=3, V_BLANK=5; enable=1, s_valid=1, s_data=incrementing from 0:
  - vsync high 21 cycles; href high 12 cycles in 3 bursts of 4; data 0..11 in order.
  - frame_done pulses once per 26-cycle frame period.
- Same params; drop s_valid for 1 cycle during line 1 pixel 2 -> href still 4 cycles, that pixel=0, underflow=1 and stays set, later pixels correct.
- Deassert enable during line 0 of frame 1 -> frame 1 completes (21 vsync cycles); after VBLANK the block enters IDLE and s_ready stays 0.
- Assert rst during an ACTIVE cycle -> vsync/href/data/s_ready are 0 in the same cycle; after release with enable=1, vsync rises 1 cycle later and the full frame is re-emitted from pixel 0.
- Check href-low cycles: out_img_data=0 throughout.
- With VIDEO_FRAME_GEN_TPG_EN and tpg_mode=1 -> s_ready never asserts; line 2 data = 2,3,4,5; underflow stays 0.
